// File: rtl/command_in_reader_pkg.sv
// Shared constants for the OmpSs manager command queues.
// Holds subqueue geometry, header word field offsets, the command reader
// FSM state encoding (shared with verification monitors) and small helpers
// for header decoding and BRAM slot addressing.
package command_in_reader_pkg;

  localparam int unsigned MAX_ACCS                = 16;
  localparam int unsigned ACC_BITS                = 4;
  localparam int unsigned SUBQUEUE_BITS           = 6;
  localparam int unsigned ENTRY_VALID_OFFSET      = 63;
  localparam int unsigned ENTRY_VALID_BYTE_OFFSET = 56;
  localparam int unsigned ENTRY_NARGS_OFFSET      = 16;
  localparam int unsigned ENTRY_ACC_OFFSET        = 8;
  localparam int unsigned ENTRY_CODE_OFFSET       = 0;
  localparam int unsigned ENTRY_FIELD_BITS        = 8;

  localparam logic [7:0] MAX_NARGS = 8'd63;

  // One-hot reader FSM encoding.
  typedef enum logic [5:0] {
    ST_SCAN     = 6'b000001,
    ST_HDR_WAIT = 6'b000010,
    ST_SEND     = 6'b000100,
    ST_FETCH    = 6'b001000,
    ST_LOAD     = 6'b010000,
    ST_CLEAR    = 6'b100000
  } reader_state_t;

  // Payload word count of a header, saturated to what fits in a subqueue.
  function automatic logic [SUBQUEUE_BITS-1:0] header_nargs(input logic [63:0] word);
    logic [ENTRY_FIELD_BITS-1:0] n;
    n = word[ENTRY_NARGS_OFFSET +: ENTRY_FIELD_BITS];
    return (n > MAX_NARGS) ? MAX_NARGS[SUBQUEUE_BITS-1:0] : n[SUBQUEUE_BITS-1:0];
  endfunction

  function automatic logic header_valid(input logic [63:0] word);
    return word[ENTRY_VALID_OFFSET];
  endfunction

  // Byte address of a queue slot: {0, acc, idx, 3'b000}.
  function automatic logic [31:0] slot_addr(input logic [ACC_BITS-1:0]      acc,
                                            input logic [SUBQUEUE_BITS-1:0] idx);
    return {{(32 - ACC_BITS - SUBQUEUE_BITS - 3){1'b0}}, acc, idx, 3'b000};
  endfunction

endpackage

// File: rtl/command_in_reader.sv
// command_in_reader: polls the per-accelerator cmdInQueue subqueues in BRAM,
// streams each valid command (header + N payload words) to its accelerator
// over AXI-Stream with TID, clears the header slot and marks the accelerator
// busy.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cmdInQueue_*              BRAM port (1-cycle read latency), clk forwarded
//   outStream_*               AXI-Stream master: TDATA/TVALID/TREADY/TID/TLAST
//   acc_avail                 per-accelerator idle flags (sampled while scanning)
//   acc_avail_clr(_address)   one-cycle pulse marking an accelerator busy
module command_in_reader
  import command_in_reader_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  output logic [31:0]         cmdInQueue_addr,
  output logic                cmdInQueue_en,
  output logic [7:0]          cmdInQueue_we,
  output logic [63:0]         cmdInQueue_din,
  input  logic [63:0]         cmdInQueue_dout,
  output logic                cmdInQueue_clk,
  output logic                cmdInQueue_rst,
  output logic [63:0]         outStream_TDATA,
  output logic                outStream_TVALID,
  input  logic                outStream_TREADY,
  output logic [ACC_BITS-1:0] outStream_TID,
  output logic                outStream_TLAST,
  input  logic [MAX_ACCS-1:0] acc_avail,
  output logic                acc_avail_clr,
  output logic [ACC_BITS-1:0] acc_avail_clr_address
);

  reader_state_t state, state_nxt;

  logic [SUBQUEUE_BITS-1:0] ridx_mem [MAX_ACCS];
  logic [ACC_BITS-1:0]      rr_ptr;
  logic [ACC_BITS-1:0]      acc;
  logic [SUBQUEUE_BITS-1:0] hdr_idx;
  logic [SUBQUEUE_BITS-1:0] cur_idx;
  logic [SUBQUEUE_BITS-1:0] remaining;
  logic [63:0]              tdata;
  logic                     scan_hit;

  assign cmdInQueue_clk        = clk;
  assign cmdInQueue_rst        = 1'b0;
  assign cmdInQueue_din        = '0;
  assign outStream_TDATA       = tdata;
  assign outStream_TID         = acc;
  assign acc_avail_clr_address = acc;

  // The scan read is combinational from state; qualifying it with rstn keeps
  // the BRAM port quiet while reset is held.
  assign scan_hit = rstn && acc_avail[rr_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    cmdInQueue_en    = 1'b0;
    cmdInQueue_we    = '0;
    cmdInQueue_addr  = '0;
    outStream_TVALID = 1'b0;
    outStream_TLAST  = 1'b0;
    acc_avail_clr    = 1'b0;
    unique case (state)
      ST_SCAN: begin
        if (scan_hit) begin
          cmdInQueue_en   = 1'b1;
          cmdInQueue_addr = slot_addr(rr_ptr, ridx_mem[rr_ptr]);
          state_nxt       = ST_HDR_WAIT;
        end
      end
      ST_HDR_WAIT: begin
        state_nxt = header_valid(cmdInQueue_dout) ? ST_SEND : ST_SCAN;
      end
      ST_SEND: begin
        outStream_TVALID = 1'b1;
        outStream_TLAST  = (remaining == '0);
        if (outStream_TREADY) state_nxt = (remaining == '0) ? ST_CLEAR : ST_FETCH;
      end
      ST_FETCH: begin
        cmdInQueue_en   = 1'b1;
        cmdInQueue_addr = slot_addr(acc, cur_idx);
        state_nxt       = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_SEND;
      end
      ST_CLEAR: begin
        cmdInQueue_en   = 1'b1;
        cmdInQueue_we   = '1;
        cmdInQueue_addr = slot_addr(acc, hdr_idx);
        acc_avail_clr   = 1'b1;
        state_nxt       = ST_SCAN;
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr    <= '0;
      acc       <= '0;
      hdr_idx   <= '0;
      cur_idx   <= '0;
      remaining <= '0;
      tdata     <= '0;
      for (int unsigned i = 0; i < MAX_ACCS; i++) ridx_mem[i] <= '0;
    end else begin
      unique case (state)
        ST_SCAN: begin
          if (acc_avail[rr_ptr]) begin
            acc     <= rr_ptr;
            hdr_idx <= ridx_mem[rr_ptr];
            cur_idx <= ridx_mem[rr_ptr];
          end else begin
            rr_ptr <= rr_ptr + 1'b1;
          end
        end
        ST_HDR_WAIT: begin
          if (!header_valid(cmdInQueue_dout)) begin
            rr_ptr <= rr_ptr + 1'b1;
          end else begin
            tdata     <= cmdInQueue_dout;
            remaining <= header_nargs(cmdInQueue_dout);
          end
        end
        ST_SEND: begin
          if (outStream_TREADY && remaining != '0) begin
            cur_idx   <= cur_idx + 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        ST_LOAD: begin
          tdata <= cmdInQueue_dout;
        end
        ST_CLEAR: begin
          // cur_idx has advanced to header + N, so the next command starts one past it.
          ridx_mem[acc] <= cur_idx + 1'b1;
          rr_ptr        <= acc + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_command_in_reader.sv
module tb_command_in_reader;
  import command_in_reader_pkg::*;

  typedef struct {
    int          acc;
    int          slot;
    int          nfield;
    int          code;
    int          mode;       // 0: TREADY high, 1: TREADY toggles
    int          exp_beats;
    logic [31:0] exp_clr;    // byte address of the cleared header slot
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tid;
    logic        tlast;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  we;
    logic [63:0] din;
    int          cyc;
  } bram_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addr;
  logic        en;
  logic [7:0]  we;
  logic [63:0] din;
  logic [63:0] dout = '0;
  logic        bram_clk, bram_rst;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic [3:0]  tid;
  logic        tlast;
  logic [15:0] acc_avail = '0;
  logic        clr;
  logic [3:0]  clr_addr;

  logic        host_we = 1'b0;
  logic [9:0]  host_idx = '0;
  logic [63:0] host_data = '0;
  logic [63:0] mem [1024] = '{default: '0};
  int          tready_mode = 0;

  beat_t       beats[$];
  bram_t       rds[$];
  bram_t       wrs[$];
  logic [3:0]  clrs[$];
  int          stab_viol = 0;
  int          cyc = 0;

  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  command_in_reader dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .cmdInQueue_addr       (addr),
    .cmdInQueue_en         (en),
    .cmdInQueue_we         (we),
    .cmdInQueue_din        (din),
    .cmdInQueue_dout       (dout),
    .cmdInQueue_clk        (bram_clk),
    .cmdInQueue_rst        (bram_rst),
    .outStream_TDATA       (tdata),
    .outStream_TVALID      (tvalid),
    .outStream_TREADY      (tready),
    .outStream_TID         (tid),
    .outStream_TLAST       (tlast),
    .acc_avail             (acc_avail),
    .acc_avail_clr         (clr),
    .acc_avail_clr_address (clr_addr)
  );

  // BRAM model: one-cycle registered read, full-word write, plus a host port.
  always @(posedge clk) begin
    if (host_we) mem[host_idx] <= host_data;
    if (en) begin
      if (we == 8'hFF) mem[addr[12:3]] <= din;
      dout <= mem[addr[12:3]];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = 1'b0;
      endcase
    end
  end

  // Monitor: records handshakes, BRAM accesses and clear pulses; watches
  // AXI-Stream stability while stalled.
  initial begin
    logic        prev_stall;
    logic [63:0] p_data;
    logic [3:0]  p_tid;
    logic        p_tlast;
    prev_stall = 1'b0;
    p_data = '0; p_tid = '0; p_tlast = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (prev_stall && (!tvalid || tdata !== p_data || tid !== p_tid || tlast !== p_tlast))
          stab_viol++;
        if (tvalid && tready) beats.push_back('{tdata, tid, tlast, cyc});
        if (en && we != 8'h00) wrs.push_back('{addr, we, din, cyc});
        else if (en)           rds.push_back('{addr, we, din, cyc});
        if (clr) clrs.push_back(clr_addr);
      end
      prev_stall = rstn && tvalid && !tready;
      p_data = tdata; p_tid = tid; p_tlast = tlast;
    end
  end

  function automatic logic [63:0] hdr(int n, int a, int c);
    return {8'h80, 32'h3C00_A5A5, 8'(n), 8'(a), 8'(c)};
  endfunction

  function automatic logic [63:0] pay(int a, int s, int k);
    return {8'h5A, 8'(a), 8'(s), 8'(k), 32'h1234_C0DE};
  endfunction

  function automatic int clampn(int n);
    return (n > 63) ? 63 : n;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_wr(int a, int s, logic [63:0] d);
    @(posedge clk);
    #1;
    host_we = 1'b1; host_idx = 10'(a * 64 + s); host_data = d;
    @(posedge clk);
    #1;
    host_we = 1'b0;
  endtask

  task automatic load_cmd(int a, int s, int n, int c);
    host_wr(a, s, hdr(n, a, c));
    for (int k = 1; k <= clampn(n); k++) host_wr(a, (s + k) % 64, pay(a, (s + k) % 64, k));
  endtask

  task automatic set_avail(logic [15:0] v);
    @(posedge clk);
    #1;
    acc_avail = v;
  endtask

  task automatic wait_clr(int target, string name);
    for (int i = 0; i < 3000 && clrs.size() < target; i++) @(negedge clk);
    n_checks++;
    if (clrs.size() < target) begin
      n_fail++;
      $display("FAIL %s timeout: clears %0d required %0d", name, clrs.size(), target);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int b0, w0, r0, c0, nacc4;
    logic [63:0] rr_data [5];
    logic [3:0]  rr_tid  [5];
    logic        rr_last [5];
    logic [31:0] rr_wr   [3];
    logic [3:0]  rr_clr  [3];

    vecs[0] = '{3,  0,  2,   8'h01, 0, 3,  32'h0000_0600};
    vecs[1] = '{5,  0,  61,  8'h02, 0, 62, 32'h0000_0A00};
    vecs[2] = '{5,  62, 3,   8'h03, 0, 4,  32'h0000_0BF0};
    vecs[3] = '{5,  2,  0,   8'h04, 1, 1,  32'h0000_0A10};
    vecs[4] = '{7,  0,  255, 8'h05, 0, 64, 32'h0000_0E00};
    vecs[5] = '{7,  0,  1,   8'h06, 1, 2,  32'h0000_0E00};
    vecs[6] = '{15, 0,  1,   8'h7F, 0, 2,  32'h0000_1E00};
    vecs[7] = '{10, 0,  3,   8'h0A, 1, 4,  32'h0000_1400};

    // Reset state, with every accelerator advertised idle.
    acc_avail = '1;
    repeat (3) @(negedge clk);
    check("rst tvalid", 64'(tvalid), 0);
    check("rst tlast", 64'(tlast), 0);
    check("rst tdata", tdata, 0);
    check("rst tid", 64'(tid), 0);
    check("rst en", 64'(en), 0);
    check("rst we", 64'(we), 0);
    check("rst din", din, 0);
    check("rst addr", 64'(addr), 0);
    check("rst clr", 64'(clr), 0);
    check("rst clr_addr", 64'(clr_addr), 0);
    check("bram rst", 64'(bram_rst), 0);
    @(posedge clk);
    #1;
    acc_avail = '0;
    rstn = 1'b1;

    // Directed command vectors; each one starts where the previous left the pointer.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      load_cmd(v.acc, v.slot, v.nfield, v.code);
      @(negedge clk);
      tready_mode = v.mode;
      b0 = beats.size(); w0 = wrs.size(); r0 = rds.size(); c0 = clrs.size();
      set_avail(16'(1 << v.acc));
      wait_clr(c0 + 1, $sformatf("v%0d clear", i));
      repeat (3) @(negedge clk);
      acc_avail = '0;
      tready_mode = 0;
      repeat (4) @(negedge clk);
      check($sformatf("v%0d beats", i), 64'(beats.size() - b0), 64'(v.exp_beats));
      for (int k = 0; k < v.exp_beats && b0 + k < beats.size(); k++) begin
        logic [63:0] e;
        e = (k == 0) ? hdr(v.nfield, v.acc, v.code) : pay(v.acc, (v.slot + k) % 64, k);
        check($sformatf("v%0d b%0d data", i, k), beats[b0 + k].data, e);
        check($sformatf("v%0d b%0d tid", i, k), 64'(beats[b0 + k].tid), 64'(v.acc));
        check($sformatf("v%0d b%0d tlast", i, k), 64'(beats[b0 + k].tlast), 64'(k == v.exp_beats - 1));
      end
      check($sformatf("v%0d writes", i), 64'(wrs.size() - w0), 1);
      if (wrs.size() > w0) begin
        check($sformatf("v%0d wr addr", i), 64'(wrs[w0].addr), 64'(v.exp_clr));
        check($sformatf("v%0d wr din", i), wrs[w0].din, 0);
        check($sformatf("v%0d wr we", i), 64'(wrs[w0].we), 64'hFF);
      end
      if (clrs.size() > c0) check($sformatf("v%0d clr id", i), 64'(clrs[c0]), 64'(v.acc));
      if (i == 0 && rds.size() > r0 && beats.size() > b0 + 1) begin
        check("v0 hdr rd addr", 64'(rds[r0].addr), 64'h600);
        check("v0 tvalid latency", 64'(beats[b0].cyc - rds[r0].cyc), 2);
        check("v0 beat spacing", 64'(beats[b0 + 1].cyc - beats[b0].cyc), 3);
      end
    end
    check("stream stable while stalled", 64'(stab_viol), 0);

    // Invalid header at acc 2, then a valid one at unavailable acc 4.
    host_wr(2, 0, 64'h7F00_0000_0003_0201);
    b0 = beats.size(); w0 = wrs.size(); r0 = rds.size(); c0 = clrs.size();
    set_avail(16'h0004);
    repeat (100) @(negedge clk);
    check("inv beats", 64'(beats.size() - b0), 0);
    check("inv writes", 64'(wrs.size() - w0), 0);
    check("inv clears", 64'(clrs.size() - c0), 0);
    check("inv polled", 64'(rds.size() > r0), 1);
    load_cmd(4, 0, 1, 8'h44);
    repeat (100) @(negedge clk);
    nacc4 = 0;
    for (int k = r0; k < rds.size(); k++) if (rds[k].addr[12:9] == 4'd4) nacc4++;
    check("unavail reads", 64'(nacc4), 0);
    check("unavail beats", 64'(beats.size() - b0), 0);
    set_avail(16'h0014);
    wait_clr(c0 + 1, "acc4 clear");
    repeat (3) @(negedge clk);
    acc_avail = '0;
    check("acc4 beats", 64'(beats.size() - b0), 2);
    if (beats.size() > b0 + 1) begin
      check("acc4 b0 data", beats[b0].data, hdr(1, 4, 8'h44));
      check("acc4 b1 data", beats[b0 + 1].data, pay(4, 1, 1));
      check("acc4 tid", 64'(beats[b0 + 1].tid), 4);
    end
    if (wrs.size() > w0) check("acc4 wr addr", 64'(wrs[w0].addr), 64'h800);

    // Reset while beat 1 of a 3-beat command is stalled.
    load_cmd(9, 0, 2, 8'h09);
    @(negedge clk);
    tready_mode = 2;
    b0 = beats.size(); c0 = clrs.size();
    set_avail(16'h0200);
    for (int i = 0; i < 500 && !tvalid; i++) @(negedge clk);
    check("rsttest hdr tvalid", 64'(tvalid), 1);
    tready_mode = 0;
    @(negedge clk);
    tready_mode = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tvalid) break;
    end
    check("rsttest beats before", 64'(beats.size() - b0), 1);
    check("rsttest stalled data", tdata, pay(9, 1, 1));
    #2;
    rstn = 1'b0;
    #1;
    check("async tvalid", 64'(tvalid), 0);
    check("async tlast", 64'(tlast), 0);
    check("async tdata", tdata, 0);
    check("async tid", 64'(tid), 0);
    check("async en", 64'(en), 0);
    check("async addr", 64'(addr), 0);
    check("async no clear", 64'(clrs.size() - c0), 0);
    if (beats.size() > b0) check("abandoned tlast", 64'(beats[b0].tlast), 0);

    // Round-robin after reset: acc 0 then acc 1, then the second acc 0 command.
    tready_mode = 0;
    acc_avail = 16'h0003;
    load_cmd(0, 0, 1, 8'h10);
    load_cmd(0, 2, 0, 8'h12);
    load_cmd(1, 0, 1, 8'h11);
    rr_data = '{hdr(1, 0, 8'h10), pay(0, 1, 1), hdr(1, 1, 8'h11), pay(1, 1, 1), hdr(0, 0, 8'h12)};
    rr_tid  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
    rr_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rr_wr   = '{32'h000, 32'h200, 32'h010};
    rr_clr  = '{4'd0, 4'd1, 4'd0};
    b0 = beats.size(); w0 = wrs.size(); r0 = rds.size(); c0 = clrs.size();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_clr(c0 + 3, "rr clears");
    repeat (3) @(negedge clk);
    acc_avail = '0;
    if (rds.size() > r0) check("post-reset first read", 64'(rds[r0].addr), 0);
    check("rr beats", 64'(beats.size() - b0), 5);
    for (int k = 0; k < 5 && b0 + k < beats.size(); k++) begin
      check($sformatf("rr b%0d data", k), beats[b0 + k].data, rr_data[k]);
      check($sformatf("rr b%0d tid", k), 64'(beats[b0 + k].tid), 64'(rr_tid[k]));
      check($sformatf("rr b%0d tlast", k), 64'(beats[b0 + k].tlast), 64'(rr_last[k]));
    end
    check("rr writes", 64'(wrs.size() - w0), 3);
    for (int k = 0; k < 3 && w0 + k < wrs.size(); k++)
      check($sformatf("rr wr%0d addr", k), 64'(wrs[w0 + k].addr), 64'(rr_wr[k]));
    for (int k = 0; k < 3 && c0 + k < clrs.size(); k++)
      check($sformatf("rr clr%0d id", k), 64'(clrs[c0 + k]), 64'(rr_clr[k]));
    check("final stability", 64'(stab_viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
